// File: rtl/ps2_pkg.sv
// ps2_pkg: frame FSM states and PS/2 frame constants shared by the receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/ps2_pkt_fifo.sv
// ps2_pkt_fifo: first-word-fall-through packet FIFO; a push into a full FIFO is accepted only alongside a pop
module ps2_pkt_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   vld,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   accepted
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_pop;
  assign vld = level != '0;
  assign do_pop = pop & vld;
  assign accepted = push & ((level != (AW+1)'(DEPTH)) | do_pop);
  assign head = vld ? mem[rp] : '0;
  // storage write; the head is masked to zero while empty so no reset is needed here
  always_ff @(posedge clk)
    if (accepted) mem[wp] <= push_data;
  // pointers and occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(accepted);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(accepted) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ps2_pkt_rx.sv
// ps2_pkt_rx: PS/2 receiver that filters the line clock, deframes bytes and queues multi-byte packets
module ps2_pkt_rx
  import ps2_pkg::*;
#(
  parameter int PKT_BYTES   = 3,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk_sys,
  input  logic                        rst,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DATA,
  input  logic                        rx_en,
  input  logic                        clr_sticky,
  output logic                        pkt_vld,
  input  logic                        pkt_rdy,
  output logic [8*PKT_BYTES-1:0]      pkt_data,
  output logic                        pkt_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        ovf_sticky,
  output logic                        to_sticky
);
  localparam int PW = 8*PKT_BYTES;
  localparam int IW = PKT_BYTES > 1 ? $clog2(PKT_BYTES) : 1;
  localparam int FW = $clog2(FILT_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [1:0] clk_s, dat_s;
  logic fclk, fclk_d;
  logic [FW-1:0] fcnt;
  state_t state, nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par;
  logic [IW-1:0] byte_idx;
  logic [PW-1:0] asm_reg, pkt_w;
  logic asm_err, byte_err, stb, dat, done, last, push, accepted, active, to_hit, abort;
  logic [TW-1:0] tcnt;
  logic [PW:0] head;
  assign stb = fclk_d & ~fclk;
  assign dat = dat_s[1];
  assign active = (state != IDLE) || (byte_idx != '0);
  assign to_hit = rx_en & active & ~stb & (tcnt == TW'(TIMEOUT_CYC-1));
  assign abort = ~rx_en | to_hit;
  assign done = stb & ~abort & (state == STOP);
  assign byte_err = (par != ~^shreg) | (dat != STOP_BIT);
  assign last = byte_idx == IW'(PKT_BYTES-1);
  assign push = done & last;
  assign pkt_data = head[PW-1:0];
  assign pkt_err = head[PW];
  // synchronisers and clock glitch filter: a new level needs FILT_LEN consecutive samples
  always_ff @(posedge clk_sys)
    if (rst) begin
      clk_s <= '1;
      dat_s <= '1;
      fclk <= 1'b1;
      fclk_d <= 1'b1;
      fcnt <= '0;
    end else begin
      clk_s <= {clk_s[0], PS2_CLK};
      dat_s <= {dat_s[0], PS2_DATA};
      fclk_d <= fclk;
      if (clk_s[1] == fclk) fcnt <= '0;
      else if (fcnt == FW'(FILT_LEN-1)) begin
        fclk <= clk_s[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  // packet image with the byte currently in the deserialiser dropped into its lane
  always_comb begin
    pkt_w = asm_reg;
    pkt_w[byte_idx*8 +: 8] = shreg;
  end
  // frame FSM next state
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else if (stb)
      case (state)
        IDLE:    nxt = dat == START_BIT ? DATA : IDLE;
        DATA:    nxt = bit_cnt == 3'(DATA_BITS-1) ? PARITY : DATA;
        PARITY:  nxt = STOP;
        default: nxt = IDLE;
      endcase
  end
  // frame FSM state register
  always_ff @(posedge clk_sys)
    state <= rst ? IDLE : nxt;
  // deserialiser and packet assembly; abort discards everything partial
  always_ff @(posedge clk_sys)
    if (rst || abort) begin
      bit_cnt <= '0;
      byte_idx <= '0;
      asm_err <= 1'b0;
      shreg <= '0;
      par <= 1'b0;
      asm_reg <= '0;
    end else if (stb) begin
      if (state == IDLE) bit_cnt <= '0;
      if (state == DATA) begin
        shreg <= {dat, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == PARITY) par <= dat;
      if (state == STOP) begin
        asm_reg <= pkt_w;
        byte_idx <= last ? '0 : byte_idx + 1'b1;
        asm_err <= ~last & (asm_err | byte_err);
      end
    end
  // inactivity timer, restarted by every bit strobe
  always_ff @(posedge clk_sys)
    tcnt <= (rst || abort || stb || !active) ? '0 : tcnt + 1'b1;
  // sticky flags; a setting event beats a clear in the same cycle
  always_ff @(posedge clk_sys)
    if (rst) begin
      ovf_sticky <= 1'b0;
      to_sticky <= 1'b0;
    end else begin
      ovf_sticky <= (push & ~accepted) | (ovf_sticky & ~clr_sticky);
      to_sticky <= to_hit | (to_sticky & ~clr_sticky);
    end
  ps2_pkt_fifo #(.WIDTH(PW+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_sys),
    .rst(rst),
    .push(push),
    .push_data({asm_err | byte_err, pkt_w}),
    .pop(pkt_rdy),
    .vld(pkt_vld),
    .head(head),
    .level(fifo_level),
    .accepted(accepted)
  );
endmodule
